// File: rtl/spi_master_ctrl_if.sv
// Bundle between spi_master_ctrl and its surroundings: host request/response,
// SPI pins, and the command port of the companion shift register.
`timescale 1ns/1ps

interface spi_master_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] tx_data;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] rx_data;
  logic             sclk;
  logic             cs_n;
  logic             mosi;
  logic             miso;
  logic [1:0]       sr_mode;
  logic [WIDTH-1:0] sr_pin;
  logic             sr_sin;
  logic [WIDTH-1:0] sr_pout;

  modport master (
    input  start, tx_data, miso, sr_pout,
    output ready, done, rx_data, sclk, cs_n, mosi, sr_mode, sr_pin, sr_sin
  );

  modport slave (
    output start, tx_data, miso, sr_pout,
    input  ready, done, rx_data, sclk, cs_n, mosi, sr_mode, sr_pin, sr_sin
  );
endinterface

// File: rtl/spi_master_ctrl.sv
// SPI mode-0 master sequencer driving an external mode-controlled shift register.
// Define SPI_BURST_EN to keep cs_n low across back-to-back transfers.
`timescale 1ns/1ps

module spi_master_ctrl #(
  parameter int WIDTH   = 8,
  parameter int CLK_DIV = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  spi_master_ctrl_if.master     bus_if
);

  localparam int BW = $clog2(WIDTH);
  localparam int DW = $clog2(CLK_DIV + 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_SHIFT = 2'b10;
  localparam logic [1:0] MODE_LOAD  = 2'b11;

  typedef enum logic [2:0] {IDLE, LOAD, LOW, HIGH, DONE} state_e;

  state_e           state_q, state_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [DW-1:0]    div_q, div_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;
  logic             sclk_q, sclk_d;
  logic             cs_n_q, cs_n_d;
  logic [1:0]       sr_mode_q, sr_mode_d;
  logic [WIDTH-1:0] sr_pin_q, sr_pin_d;
  logic             sr_sin_q, sr_sin_d;

  logic accept;
  logic div_end;

  assign accept  = bus_if.start && ready_q;
  assign div_end = (div_q == DIV_LAST);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bit_q     <= '0;
      div_q     <= '0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      sclk_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      sr_mode_q <= MODE_HOLD;
      sr_pin_q  <= '0;
      sr_sin_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_q     <= bit_d;
      div_q     <= div_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
      sclk_q    <= sclk_d;
      cs_n_q    <= cs_n_d;
      sr_mode_q <= sr_mode_d;
      sr_pin_q  <= sr_pin_d;
      sr_sin_q  <= sr_sin_d;
    end
  end

  // DONE lasts two cycles: the final shift settles in the first, the
  // done/ready pulse is visible in the second.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = LOAD;
      LOAD: state_d = LOW;
      LOW:  if (div_end) state_d = HIGH;
      HIGH: if (div_end) state_d = (bit_q == BIT_LAST) ? DONE : LOW;
      DONE: if (div_q != '0) state_d = accept ? LOAD : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    bit_d     = bit_q;
    div_d     = div_q;
    ready_d   = ready_q;
    done_d    = 1'b0;
    sclk_d    = sclk_q;
    cs_n_d    = cs_n_q;
    sr_mode_d = MODE_HOLD;
    sr_pin_d  = sr_pin_q;
    sr_sin_d  = sr_sin_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          sr_pin_d  = bus_if.tx_data;
          sr_mode_d = MODE_LOAD;
          cs_n_d    = 1'b0;
          ready_d   = 1'b0;
        end
      end
      LOAD: begin
        div_d = '0;
        bit_d = '0;
      end
      LOW: begin
        if (div_end) begin
          div_d    = '0;
          sclk_d   = 1'b1;
          sr_sin_d = bus_if.miso;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      HIGH: begin
        if (div_end) begin
          div_d     = '0;
          sclk_d    = 1'b0;
          sr_mode_d = MODE_SHIFT;
          if (bit_q != BIT_LAST) begin
            bit_d = bit_q + 1'b1;
          end else begin
`ifdef SPI_BURST_EN
            cs_n_d = 1'b0;
`else
            cs_n_d = 1'b1;
`endif
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      DONE: begin
        if (div_q == '0) begin
          div_d   = DW'(1);
          done_d  = 1'b1;
          ready_d = 1'b1;
        end else if (accept) begin
          sr_pin_d  = bus_if.tx_data;
          sr_mode_d = MODE_LOAD;
          cs_n_d    = 1'b0;
          ready_d   = 1'b0;
        end else begin
          cs_n_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign bus_if.ready   = ready_q;
  assign bus_if.done    = done_q;
  assign bus_if.sclk    = sclk_q;
  assign bus_if.cs_n    = cs_n_q;
  assign bus_if.sr_mode = sr_mode_q;
  assign bus_if.sr_pin  = sr_pin_q;
  assign bus_if.sr_sin  = sr_sin_q;
  assign bus_if.rx_data = bus_if.sr_pout;
  assign bus_if.mosi    = bus_if.sr_pout[WIDTH-1];

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl: two instances (CLK_DIV 2 and 1), each
// paired with a behavioural shift register and a mode-0 slave driving miso.
`timescale 1ns/1ps

module tb_spi_master_ctrl;

  logic       clk;
  logic       rst_n;
  logic       sel;
  logic       start_drv;
  logic [7:0] tx_drv;
  logic       miso_drv;
  logic [7:0] sr0, sr1;

  int n_vec;
  int n_bad;

  logic       obs_ready, obs_done, obs_sclk, obs_cs_n, obs_mosi;
  logic [1:0] obs_mode;
  logic [7:0] obs_rx;

  spi_master_ctrl_if #(.WIDTH(8)) bus0 ();
  spi_master_ctrl_if #(.WIDTH(8)) bus1 ();

  spi_master_ctrl #(.WIDTH(8), .CLK_DIV(2)) dut0 (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_if (bus0)
  );

  spi_master_ctrl #(.WIDTH(8), .CLK_DIV(1)) dut1 (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_if (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus0.start   = (sel == 1'b0) ? start_drv : 1'b0;
  assign bus1.start   = (sel == 1'b1) ? start_drv : 1'b0;
  assign bus0.tx_data = tx_drv;
  assign bus1.tx_data = tx_drv;
  assign bus0.miso    = miso_drv;
  assign bus1.miso    = miso_drv;
  assign bus0.sr_pout = sr0;
  assign bus1.sr_pout = sr1;

  // Companion shift registers: 00 hold, 10 left shift, 11 parallel load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr0 <= '0;
      sr1 <= '0;
    end else begin
      if (bus0.sr_mode == 2'b11)      sr0 <= bus0.sr_pin;
      else if (bus0.sr_mode == 2'b10) sr0 <= {sr0[6:0], bus0.sr_sin};
      if (bus1.sr_mode == 2'b11)      sr1 <= bus1.sr_pin;
      else if (bus1.sr_mode == 2'b10) sr1 <= {sr1[6:0], bus1.sr_sin};
    end
  end

  always_comb begin
    if (sel == 1'b0) begin
      obs_ready = bus0.ready;   obs_done = bus0.done;  obs_sclk = bus0.sclk;
      obs_cs_n  = bus0.cs_n;    obs_mosi = bus0.mosi;  obs_mode = bus0.sr_mode;
      obs_rx    = bus0.rx_data;
    end else begin
      obs_ready = bus1.ready;   obs_done = bus1.done;  obs_sclk = bus1.sclk;
      obs_cs_n  = bus1.cs_n;    obs_mosi = bus1.mosi;  obs_mode = bus1.sr_mode;
      obs_rx    = bus1.rx_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      for (int s = 0; s < 2; s++) begin
        sel = s[0];
        #1;
        n_vec++;
        if (obs_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready dut%0d cyc%0d: got %b want 1", s, c, obs_ready); end
        n_vec++;
        if (obs_cs_n !== 1'b1) begin n_bad++; $display("FAIL reset_cs_n dut%0d cyc%0d: got %b want 1", s, c, obs_cs_n); end
        n_vec++;
        if (obs_sclk !== 1'b0) begin n_bad++; $display("FAIL reset_sclk dut%0d cyc%0d: got %b want 0", s, c, obs_sclk); end
        n_vec++;
        if (obs_mode !== 2'b00) begin n_bad++; $display("FAIL reset_mode dut%0d cyc%0d: got %b want 00", s, c, obs_mode); end
        n_vec++;
        if (obs_done !== 1'b0) begin n_bad++; $display("FAIL reset_done dut%0d cyc%0d: got %b want 0", s, c, obs_done); end
      end
    end
    sel = 1'b0;
  endtask

  // One full transfer on the selected DUT; pulse_at<0 means no extra start pulse.
  task automatic run_xfer(input string name, input logic [7:0] tx, input logic [7:0] pat,
                          input int cd, input int pulse_at);
    int   rises, falls, done_cnt, done_t, bad_mode, t_end;
    logic prev_sclk;
    rises = 0; falls = 0; done_cnt = 0; done_t = -1; bad_mode = 0;
    t_end = 2 + 2 * cd * 8 + 6;
    miso_drv  = pat[7];
    tx_drv    = tx;
    start_drv = 1'b1;
    tick();
    start_drv = 1'b0;
    tx_drv    = ~tx;
    n_vec++;
    if (obs_cs_n !== 1'b0) begin n_bad++; $display("FAIL %s_cs_fall: got %b want 0", name, obs_cs_n); end
    n_vec++;
    if (obs_mode !== 2'b11) begin n_bad++; $display("FAIL %s_load_mode: got %b want 11", name, obs_mode); end
    n_vec++;
    if (obs_ready !== 1'b0) begin n_bad++; $display("FAIL %s_busy: got %b want 0", name, obs_ready); end
    prev_sclk = obs_sclk;
    for (int t = 1; t <= t_end; t++) begin
      start_drv = (t == pulse_at);
      tick();
      if (obs_mode === 2'b11) bad_mode++;
      if (obs_sclk === 1'b1 && prev_sclk === 1'b0) begin
        if (rises < 8) begin
          n_vec++;
          if (obs_mosi !== tx[7 - rises]) begin
            n_bad++; $display("FAIL %s_mosi bit%0d: got %b want %b", name, rises, obs_mosi, tx[7 - rises]);
          end
          n_vec++;
          if (t != 1 + cd * (2 * rises + 1)) begin
            n_bad++; $display("FAIL %s_rise_time bit%0d: got S+%0d want S+%0d", name, rises, t, 1 + cd * (2 * rises + 1));
          end
        end
        rises++;
      end
      if (obs_sclk === 1'b0 && prev_sclk === 1'b1) begin
        falls++;
        if (falls < 8) miso_drv = pat[7 - falls];
      end
      if (obs_done === 1'b1) begin
        done_cnt++;
        done_t = t;
        n_vec++;
        if (obs_rx !== pat) begin n_bad++; $display("FAIL %s_rx: got %h want %h", name, obs_rx, pat); end
      end
      prev_sclk = obs_sclk;
    end
    start_drv = 1'b0;
    n_vec++;
    if (rises != 8) begin n_bad++; $display("FAIL %s_rises: got %0d want 8", name, rises); end
    n_vec++;
    if (done_cnt != 1) begin n_bad++; $display("FAIL %s_done_count: got %0d want 1", name, done_cnt); end
    n_vec++;
    if (done_t != 2 + 2 * cd * 8) begin n_bad++; $display("FAIL %s_latency: got %0d want %0d", name, done_t, 2 + 2 * cd * 8); end
    n_vec++;
    if (bad_mode != 0) begin n_bad++; $display("FAIL %s_stray_load: got %0d want 0", name, bad_mode); end
    n_vec++;
    if (obs_ready !== 1'b1 || obs_cs_n !== 1'b1) begin
      n_bad++; $display("FAIL %s_end_idle: got ready=%b cs_n=%b want 1 1", name, obs_ready, obs_cs_n);
    end
  endtask

  task automatic test_basic();
    sel = 1'b0;
    run_xfer("basic", 8'hA5, 8'h3C, 2, -1);
  endtask

  task automatic test_clk_div1();
    sel = 1'b1;
    run_xfer("div1", 8'hFF, 8'h00, 1, -1);
    sel = 1'b0;
  endtask

  task automatic test_ignore_start();
    sel = 1'b0;
    run_xfer("ignore", 8'h96, 8'h69, 2, 5);
  endtask

  task automatic test_reset_mid();
    sel = 1'b0;
    miso_drv  = 1'b1;
    tx_drv    = 8'hF0;
    start_drv = 1'b1;
    tick();
    start_drv = 1'b0;
    for (int t = 1; t < 10; t++) tick();
    n_vec++;
    if (obs_cs_n !== 1'b0 || obs_ready !== 1'b0) begin
      n_bad++; $display("FAIL rstmid_pre: got cs_n=%b ready=%b want 0 0", obs_cs_n, obs_ready);
    end
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (obs_cs_n !== 1'b1) begin n_bad++; $display("FAIL rstmid_cs_n: got %b want 1", obs_cs_n); end
    n_vec++;
    if (obs_sclk !== 1'b0) begin n_bad++; $display("FAIL rstmid_sclk: got %b want 0", obs_sclk); end
    n_vec++;
    if (obs_ready !== 1'b1) begin n_bad++; $display("FAIL rstmid_ready: got %b want 1", obs_ready); end
    tick();
    rst_n = 1'b1;
    tick();
    run_xfer("after_rst", 8'h5A, 8'hC3, 2, -1);
  endtask

  task automatic test_back_to_back();
    int   accepts, done_cnt, rises, cs_high;
    logic pre_ready, prev_sclk;
    sel = 1'b0;
    accepts = 0; done_cnt = 0; rises = 0; cs_high = 0;
    miso_drv  = 1'b0;
    tx_drv    = 8'h12;
    start_drv = 1'b1;
    prev_sclk = obs_sclk;
    for (int t = 0; t < 120 && done_cnt < 2; t++) begin
      pre_ready = obs_ready;
      tick();
      if (pre_ready === 1'b1 && start_drv === 1'b1) begin
        accepts++;
        if (accepts == 1) tx_drv = 8'h34;
        if (accepts == 2) start_drv = 1'b0;
      end
      if (accepts > 0 && obs_cs_n !== 1'b0) cs_high++;
      if (obs_sclk === 1'b1 && prev_sclk === 1'b0) rises++;
      if (obs_done === 1'b1) done_cnt++;
      prev_sclk = obs_sclk;
    end
    start_drv = 1'b0;
    n_vec++;
    if (accepts != 2) begin n_bad++; $display("FAIL b2b_accepts: got %0d want 2", accepts); end
    n_vec++;
    if (done_cnt != 2) begin n_bad++; $display("FAIL b2b_done_count: got %0d want 2", done_cnt); end
    n_vec++;
    if (rises != 16) begin n_bad++; $display("FAIL b2b_sclk_pulses: got %0d want 16", rises); end
`ifdef SPI_BURST_EN
    n_vec++;
    if (cs_high != 0) begin n_bad++; $display("FAIL b2b_cs_gap: got %0d high cycles want 0", cs_high); end
`else
    n_vec++;
    if (cs_high < 1) begin n_bad++; $display("FAIL b2b_cs_gap: got %0d high cycles want >=1", cs_high); end
`endif
    for (int t = 0; t < 4; t++) tick();
    n_vec++;
    if (obs_cs_n !== 1'b1 || obs_ready !== 1'b1) begin
      n_bad++; $display("FAIL b2b_end_idle: got cs_n=%b ready=%b want 1 1", obs_cs_n, obs_ready);
    end
  endtask

  initial begin
    n_vec     = 0;
    n_bad     = 0;
    sel       = 1'b0;
    rst_n     = 1'b0;
    start_drv = 1'b0;
    tx_drv    = 8'h00;
    miso_drv  = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_clk_div1();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/spi_master_ctrl.md
# spi_master_ctrl

SPI master sequencer (mode 0: CPOL=0, CPHA=0, MSB first) that drives a companion `WIDTH`-bit mode-controlled shift register. It accepts one transfer request at a time, parallel-loads the register, and generates `sclk` and `cs_n`. On each bit it samples `miso` and commands a left shift. It returns received data through the register's parallel output, and sits between the host-side request logic and the SPI pins.

## Interface
- `WIDTH`, 8: bits per transfer; ≥2.
- `CLK_DIV`, 2: `clk` cycles per `sclk` half-period; ≥1.

- `clk` in 1: system clock; all state updates on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: transfer request; accepted only when `start && ready`.
- `tx_data` in WIDTH: transmit word; sampled at acceptance.
- `ready` out 1: controller idle, can accept `start`.
- `done` out 1: one-cycle pulse at transfer completion.
- `rx_data` out WIDTH: wire from `sr_pout`; valid from the `done` cycle until the next acceptance.
- `sclk` out 1: SPI clock, idles low.
- `cs_n` out 1: chip select, active low.
- `mosi` out 1: wire from `sr_pout[WIDTH-1]`.
- `miso` in 1: serial data from the slave.
- `sr_mode` out 2: shift register command; 00 hold, 10 left shift, 11 parallel load; 01 is never driven.
- `sr_pin` out WIDTH: parallel load value, a registered copy of `tx_data`.
- `sr_sin` out 1: serial-in for left shift, the registered `miso` sample.
- `sr_pout` in WIDTH: shift register parallel output.

## Operation
- All outputs are registered except `rx_data` and `mosi`.
- Reset values: `ready`=1, `done`=0, `sclk`=0, `cs_n`=1, `sr_mode`=00, `sr_pin`=0, `sr_sin`=0. Bit counter and divider counter reset to 0.
- States: IDLE, LOAD, LOW, HIGH, DONE.
- IDLE, on `start && ready`: `sr_pin`←`tx_data`, `sr_mode`←11, `cs_n`←0, `ready`←0; go to LOAD.
- LOAD (one cycle): `sr_mode`←00; go to LOW.
- LOW: after `CLK_DIV` cycles, `sclk`←1 and `sr_sin`←`miso` on the same edge; go to HIGH.
- HIGH: after `CLK_DIV` cycles, `sclk`←0 and `sr_mode`←10 for exactly one cycle, then the bit counter increments.
  - If bit counter = `WIDTH-1`, go to DONE.
  - Otherwise go to LOW.
- DONE: `done`=1 and `ready`=1 for one cycle, and `cs_n` is released (see Configuration). Then go to IDLE.
- `start` while `ready`=0 is ignored and not queued. `tx_data` changes after acceptance have no effect.
- Bit counter width is clog2(`WIDTH`). Divider counter width is clog2(`CLK_DIV`+1). Neither wraps mid-transfer.
- `rst_n` low mid-transfer immediately forces the reset values: `cs_n` high, `sclk` low, transfer abandoned. `sr_pout` contents are undefined for the host.

## Timing
Times are measured from edge S, the edge at which `start` is accepted.
- Edge S: `cs_n` falls; `sr_mode`=11 until edge S+1.
- Edge S+1: register holds `tx_data`, so `mosi` = `tx_data[WIDTH-1]`.
- Bit k, for k = 0..WIDTH-1:
  - `sclk` rises at edge S+1+CLK_DIV·(2k+1), where `miso` is sampled.
  - `sclk` falls at edge S+1+CLK_DIV·(2k+2), with the left shift applied at the following edge.
- Edge S+2+2·CLK_DIV·WIDTH: `done`=1 and `ready`=1, and `rx_data` holds the complete word.
  - Default latency is 34 cycles.
- Received word order: the first `miso` bit lands in `rx_data[WIDTH-1]`.
- `mosi` changes only on the edge after an `sclk` fall. It is stable at every `sclk` rise.

## Configuration
- `SPI_BURST_EN` defined:
  - `cs_n` stays low through the DONE cycle.
  - If `start` is accepted during DONE, `cs_n` stays low and the next transfer begins at that edge (back-to-back, no `cs_n` gap).
  - Otherwise `cs_n` rises on the edge leaving DONE.
- `SPI_BURST_EN` undefined: `cs_n` rises on the edge entering DONE. Every transfer has at least one idle cycle with `cs_n` high before the next `cs_n` fall.

## Test plan
- Reset, then idle 10 cycles -> `ready`=1, `cs_n`=1, `sclk`=0, `sr_mode`=00, `done`=0 throughout.
- `tx_data`=8'hA5, slave echoes `miso`=8'h3C, defaults -> `mosi` bits 1,0,1,0,0,1,0,1 at successive `sclk` rises; `done` exactly 34 cycles after acceptance; `rx_data`=8'h3C.
- `CLK_DIV`=1, `tx_data`=8'hFF, `miso` tied 0 -> `sclk` period 2 cycles; 8 rises; `done` at S+18; `rx_data`=8'h00.
- `start` pulsed at S+5 during a transfer -> ignored; exactly one `done`, and no `sr_mode`=11 outside edge S.
- `rst_n` low at S+10 -> same cycle `cs_n`=1, `sclk`=0, `ready`=1; the next `start` runs a full correct transfer.
- `SPI_BURST_EN` defined, `start` held high for two transfers (8'h12, 8'h34) -> `cs_n` low continuously from S to the end of the second DONE; 16 `sclk` pulses; two `done` pulses.
- `SPI_BURST_EN` undefined, same stimulus -> `cs_n` high for ≥1 cycle between the two transfers.
